dm_stage: RTL and testbench
===========================

Name: dm_stage

Overview:
- Data-memory stage of the 5-stage pipeline. Sits directly downstream of the EX/DM pipeline register.
- Consumes the memory address, store data and control bits that register produces, then performs the load or store against a word-addressed data RAM with configurable multi-cycle latency.
- Drives a stall back to upstream stages while an access is in progress.
- Contains the DM/WB pipeline register feeding write-back.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the data RAM (power of two)
LATENCY, 2, cycles per memory access, legal range 1..15

Ports:
clk  input  1  pipeline clock, all state updates on posedge
reset  input  1  asynchronous, active-high; clears state and outputs immediately
mem_read_in  input  1  load request from EX/DM
mem_write_in  input  1  store request from EX/DM
mem_address_in  input  32  byte address / ALU result from EX/DM
write_data_in  input  32  store data from EX/DM
rd_in  input  5  destination register from EX/DM
mem_to_reg_in  input  1  write-back select from EX/DM
reg_write_in  input  1  register-write enable from EX/DM
stall  output  1  combinational; upstream must hold its outputs while high
read_data_out  output  32  DM/WB: loaded word
alu_result_out  output  32  DM/WB: mem_address_in passthrough
rd_out  output  5  DM/WB: destination register
mem_to_reg_out  output  1  DM/WB: write-back select
reg_write_out  output  1  DM/WB: register-write enable
misaligned_out  output  1  DM/WB: access had address[1:0] != 0

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE, counter to 0, stall to 0, every DM/WB output to 0.
  - A pending store is discarded; the RAM is not written.
  - RAM contents are not cleared.
- Memory op = mem_read_in | mem_write_in.
- Word index = mem_address_in[log2(DEPTH_WORDS)+1:2]. Upper bits are ignored, so addresses wrap.
- States: IDLE, BUSY.
- IDLE, no memory op:
  - stall = 0.
  - At posedge, DM/WB loads alu_result_out = address, rd, mem_to_reg, reg_write; misaligned_out = 0; read_data_out holds.
- IDLE, memory op, address[1:0] != 0:
  - No RAM access; stall = 0.
  - At posedge, DM/WB loads misaligned_out = 1, reg_write_out = 0; other fields as normal.
- IDLE, aligned memory op, LATENCY == 1:
  - stall = 0.
  - At posedge, the access completes and DM/WB loads.
- IDLE, aligned memory op, LATENCY > 1:
  - stall = 1.
  - Request is captured into internal registers (address, data, ctrl). State goes to BUSY with cnt = LATENCY-1.
- BUSY:
  - stall = 1 while cnt > 1; cnt decrements each posedge.
  - When cnt == 1: stall = 0. At posedge the captured access completes, DM/WB loads from captured values, and state returns to IDLE.
  - Total input occupancy is LATENCY cycles; stall is high for LATENCY-1 of them.
- Input changes while BUSY are ignored (captured values are used).
- Bubble rule: at any posedge where stall = 1, DM/WB loads reg_write_out = 0, mem_to_reg_out = 0, rd_out = 0, misaligned_out = 0. read_data_out and alu_result_out hold.
- Completing store: RAM[word] <= data. reg_write_out forwards the captured reg_write.
- Completing load: read_data_out <= RAM[word].
- mem_read and mem_write both set: treated as a store. read_data_out gets the pre-write (old) word in the same completion.
- Back-to-back ops: a new op is accepted in the IDLE cycle immediately after completion; there is no dead cycle.
- RAM words never written read X; loads of unwritten locations are undefined.

Test Plan:
- LATENCY=2. Store 0xDEADBEEF to 0x10, then load 0x10 with rd=5, reg_write=1, mem_to_reg=1 -> stall high exactly 1 cycle per op; after the load, read_data_out=0xDEADBEEF, rd_out=5, reg_write_out=1, with bubbles (reg_write_out=0) in the stall cycles.
- Non-memory op, address 0x1234, rd=7, reg_write=1 -> stall never high; next edge alu_result_out=0x1234, rd_out=7, reg_write_out=1.
- Load from 0x13 with reg_write=1 -> stall=0; next edge misaligned_out=1, reg_write_out=0; RAM unchanged.
- Pre-store 0x11 at 0x20. Start store 0x55 to 0x20 and assert reset mid-BUSY -> stall and all outputs 0 immediately (before any clock edge); a later load of 0x20 returns 0x11.
- 0x30 holds 0xA. Request with read=1, write=1, data 0xB -> read_data_out=0xA; a subsequent load of 0x30 returns 0xB.
- DEPTH_WORDS=256. Store 0xCAFE to 0x400, load 0x0 -> 0xCAFE (wrap). LATENCY=1 rerun -> stall never asserted.

Source files
------------

// File: rtl/dm_stage.sv
// Data-memory stage: performs loads/stores against a word-addressed RAM with
// configurable multi-cycle latency, stalls upstream while busy, and holds the
// DM/WB pipeline register feeding write-back.
module dm_stage #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [31:0] mem_address_in,
    input  logic [31:0] write_data_in,
    input  logic [4:0]  rd_in,
    input  logic        mem_to_reg_in,
    input  logic        reg_write_in,
    output logic        stall,
    output logic [31:0] read_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  rd_out,
    output logic        mem_to_reg_out,
    output logic        reg_write_out,
    output logic        misaligned_out
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;

    // Request captured on entry to BUSY; inputs are ignored until completion.
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [4:0]  r_rd;
    logic        r_m2r;
    logic        r_rw;
    logic        r_rd_en;
    logic        r_wr_en;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_op_in;
    logic          w_misal_in;
    logic          w_stall;
    logic [31:0]   w_sel_addr;
    logic [31:0]   w_sel_wdata;
    logic [4:0]    w_sel_rd;
    logic          w_sel_m2r;
    logic          w_sel_rw;
    logic          w_sel_rd_en;
    logic          w_sel_wr_en;
    logic          w_sel_op;
    logic          w_sel_misal;
    logic [AW-1:0] w_sel_word;
    logic          w_complete;

    assign w_op_in    = mem_read_in | mem_write_in;
    assign w_misal_in = |mem_address_in[1:0];

    // Stall: held low during reset; otherwise high for all but the last busy cycle.
    always_comb begin
        w_stall = 1'b0;
        if (!reset) begin
            unique case (r_state)
                IDLE:    w_stall = w_op_in && !w_misal_in && (LATENCY > 1);
                BUSY:    w_stall = (r_cnt > 4'd1);
                default: w_stall = 1'b0;
            endcase
        end
    end

    assign stall = w_stall;

    // Select the live inputs in IDLE and the captured request in BUSY.
    always_comb begin
        if (r_state == BUSY) begin
            w_sel_addr  = r_addr;
            w_sel_wdata = r_wdata;
            w_sel_rd    = r_rd;
            w_sel_m2r   = r_m2r;
            w_sel_rw    = r_rw;
            w_sel_rd_en = r_rd_en;
            w_sel_wr_en = r_wr_en;
        end else begin
            w_sel_addr  = mem_address_in;
            w_sel_wdata = write_data_in;
            w_sel_rd    = rd_in;
            w_sel_m2r   = mem_to_reg_in;
            w_sel_rw    = reg_write_in;
            w_sel_rd_en = mem_read_in;
            w_sel_wr_en = mem_write_in;
        end
    end

    assign w_sel_op    = w_sel_rd_en | w_sel_wr_en;
    assign w_sel_misal = |w_sel_addr[1:0];
    // Upper address bits are dropped so accesses wrap around the RAM.
    assign w_sel_word  = w_sel_addr[AW+1:2];
    // An aligned access completes on any unstalled edge that presents it.
    assign w_complete  = !w_stall && w_sel_op && !w_sel_misal;

    // FSM: capture the request and count down the remaining access cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rd    <= 5'd0;
            r_m2r   <= 1'b0;
            r_rw    <= 1'b0;
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_stall) begin
                        r_state <= BUSY;
                        r_cnt   <= 4'(LATENCY - 1);
                        r_addr  <= mem_address_in;
                        r_wdata <= write_data_in;
                        r_rd    <= rd_in;
                        r_m2r   <= mem_to_reg_in;
                        r_rw    <= reg_write_in;
                        r_rd_en <= mem_read_in;
                        r_wr_en <= mem_write_in;
                    end
                end
                BUSY: begin
                    if (r_cnt == 4'd1) begin
                        r_state <= IDLE;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    // RAM write port; never cleared, and a store pending at reset is dropped.
    always_ff @(posedge clk) begin
        if (!reset && w_complete && w_sel_wr_en) begin
            r_mem[w_sel_word] <= w_sel_wdata;
        end
    end

    // DM/WB register: bubble while stalled, else load the selected request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_data_out  <= 32'd0;
            alu_result_out <= 32'd0;
            rd_out         <= 5'd0;
            mem_to_reg_out <= 1'b0;
            reg_write_out  <= 1'b0;
            misaligned_out <= 1'b0;
        end else if (w_stall) begin
            rd_out         <= 5'd0;
            mem_to_reg_out <= 1'b0;
            reg_write_out  <= 1'b0;
            misaligned_out <= 1'b0;
        end else begin
            alu_result_out <= w_sel_addr;
            rd_out         <= w_sel_rd;
            mem_to_reg_out <= w_sel_m2r;
            if (w_sel_op && w_sel_misal) begin
                reg_write_out  <= 1'b0;
                misaligned_out <= 1'b1;
            end else begin
                reg_write_out  <= w_sel_rw;
                misaligned_out <= 1'b0;
            end
            // Read sees the pre-write word when read and write are both set.
            if (w_complete && w_sel_rd_en) begin
                read_data_out <= r_mem[w_sel_word];
            end
        end
    end

endmodule

// File: tb/tb_dm_stage.sv
// Self-checking bench for dm_stage: directed vector table, reset-mid-access
// sequence and randomized traffic against a transaction-level memory model,
// run against a LATENCY=2 and a LATENCY=1 instance.
module tb_dm_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in;
    logic [31:0] mem_address_in, write_data_in;
    logic [4:0]  rd_in;

    logic        stall2, m2r2, rw2, mis2;
    logic [31:0] rdat2, alu2;
    logic [4:0]  rdo2;
    logic        stall1, m2r1, rw1, mis1;
    logic [31:0] rdat1, alu1;
    logic [4:0]  rdo1;

    bit          sel1;
    logic        w_stall, w_m2r, w_rw, w_mis;
    logic [31:0] w_rdat, w_alu;
    logic [4:0]  w_rdo;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    dm_stage #(.DEPTH_WORDS(256), .LATENCY(2)) dut2 (
        .clk(clk), .reset(reset),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .mem_address_in(mem_address_in), .write_data_in(write_data_in),
        .rd_in(rd_in), .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
        .stall(stall2), .read_data_out(rdat2), .alu_result_out(alu2),
        .rd_out(rdo2), .mem_to_reg_out(m2r2), .reg_write_out(rw2),
        .misaligned_out(mis2)
    );

    dm_stage #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .mem_address_in(mem_address_in), .write_data_in(write_data_in),
        .rd_in(rd_in), .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
        .stall(stall1), .read_data_out(rdat1), .alu_result_out(alu1),
        .rd_out(rdo1), .mem_to_reg_out(m2r1), .reg_write_out(rw1),
        .misaligned_out(mis1)
    );

    assign w_stall = sel1 ? stall1 : stall2;
    assign w_rdat  = sel1 ? rdat1  : rdat2;
    assign w_alu   = sel1 ? alu1   : alu2;
    assign w_rdo   = sel1 ? rdo1   : rdo2;
    assign w_m2r   = sel1 ? m2r1   : m2r2;
    assign w_rw    = sel1 ? rw1    : rw2;
    assign w_mis   = sel1 ? mis1   : mis2;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [4:0]  rdn;
        logic        m2r;
        logic        rw;
        logic [31:0] e_rdata;
        logic        e_busy;
        logic        e_mis;
        logic        e_rw;
    } vec_t;

    vec_t tbl[12];

    // Behavioural model state for the random phase.
    logic [31:0] m_mem [256];
    logic [31:0] m_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic drive_idle();
        mem_read_in    = 1'b0;
        mem_write_in   = 1'b0;
        mem_address_in = 32'd0;
        write_data_in  = 32'd0;
        rd_in          = 5'd0;
        mem_to_reg_in  = 1'b0;
        reg_write_in   = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " stall"}, {31'd0, w_stall}, 32'd0);
        chk({tag, " read_data"}, w_rdat, 32'd0);
        chk({tag, " alu_result"}, w_alu, 32'd0);
        chk({tag, " rd_out"}, {27'd0, w_rdo}, 32'd0);
        chk({tag, " ctrl"}, {29'd0, w_m2r, w_rw, w_mis}, 32'd0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        reset = 1'b1;
        drive_idle();
        #1;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One transaction: drive, count stall cycles (checking bubbles), then check DM/WB.
    task automatic run_op(input int lat, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] rdn, input logic m2r, input logic rw,
                          input logic [31:0] e_rdata, input logic e_busy,
                          input logic e_mis, input logic e_rw, input string tag);
        int n;
        @(negedge clk);
        mem_read_in    = rd;
        mem_write_in   = wr;
        mem_address_in = addr;
        write_data_in  = data;
        rd_in          = rdn;
        mem_to_reg_in  = m2r;
        reg_write_in   = rw;
        #1;
        n = 0;
        while (w_stall === 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            chk({tag, " bubble"}, {27'd0, w_rdo, w_m2r, w_rw, w_mis}, 32'd0);
        end
        chk({tag, " stall cycles"}, n, e_busy ? lat - 1 : 0);
        @(posedge clk);
        #1;
        chk({tag, " read_data"}, w_rdat, e_rdata);
        chk({tag, " alu_result"}, w_alu, addr);
        chk({tag, " rd_out"}, {27'd0, w_rdo}, {27'd0, rdn});
        chk({tag, " mem_to_reg"}, {31'd0, w_m2r}, {31'd0, m2r});
        chk({tag, " reg_write"}, {31'd0, w_rw}, {31'd0, e_rw});
        chk({tag, " misaligned"}, {31'd0, w_mis}, {31'd0, e_mis});
    endtask

    // Model-driven transaction: kind 0 non-mem, 1 load, 2 store, 3 read+write, 4 misaligned.
    task automatic model_op(input int lat, input int kind, input int word);
        logic        rd, wr, rw, m2r, op, aligned;
        logic [31:0] addr, data;
        logic [4:0]  rdn;
        rd   = (kind == 1) || (kind == 3) || (kind == 4 && $urandom_range(0, 1) == 1);
        wr   = (kind == 2) || (kind == 3) || (kind == 4 && !rd);
        data = $urandom;
        rdn  = 5'($urandom);
        rw   = 1'($urandom);
        m2r  = 1'($urandom);
        addr = ($urandom & 32'hFFFF_FC00) | (32'(word) << 2);
        if (kind == 0) addr = $urandom;
        if (kind == 4) addr = addr | 32'($urandom_range(1, 3));
        op      = rd | wr;
        aligned = (addr[1:0] == 2'b00);
        if (op && aligned && rd) m_rdata = m_mem[addr[9:2]];
        if (op && aligned && wr) m_mem[addr[9:2]] = data;
        run_op(lat, rd, wr, addr, data, rdn, m2r, rw, m_rdata,
               op && aligned, op && !aligned, (op && !aligned) ? 1'b0 : rw, "rand");
    endtask

    initial begin
        int lat;
        reset = 1'b0;
        sel1  = 1'b0;
        drive_idle();
        //            rd    wr    addr          data          rdn   m2r   rw    e_rdata       busy  mis   e_rw
        tbl[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         5'd5, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 32'h0000_1234, 32'h0,         5'd7, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,         5'd3, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         5'd4, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 32'h0000_0030, 32'h0000_000A, 5'd0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 32'h0000_0030, 32'h0000_000B, 5'd6, 1'b1, 1'b1, 32'h0000_000A, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 32'h0000_0030, 32'h0,         5'd8, 1'b1, 1'b1, 32'h0000_000B, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 32'h0000_0400, 32'h0000_CAFE, 5'd0, 1'b0, 1'b0, 32'h0000_000B, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         5'd9, 1'b1, 1'b1, 32'h0000_CAFE, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 32'h0000_0020, 32'h0000_0011, 5'd0, 1'b0, 1'b0, 32'h0000_CAFE, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 32'h0000_0021, 32'h0000_0099, 5'd2, 1'b0, 1'b1, 32'h0000_CAFE, 1'b0, 1'b1, 1'b0};

        #1 reset = 1'b1;
        #1;
        check_zero("initial reset");
        @(negedge clk);
        reset = 1'b0;

        for (int p = 0; p < 2; p++) begin
            sel1 = (p == 1);
            lat  = (p == 1) ? 1 : 2;
            reset_pulse();
            for (int i = 0; i < 12; i++) begin
                run_op(lat, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].rdn,
                       tbl[i].m2r, tbl[i].rw, tbl[i].e_rdata, tbl[i].e_busy,
                       tbl[i].e_mis, tbl[i].e_rw, $sformatf("vec%0d", i));
            end
            if (lat == 2) begin
                // Store 0x55 to 0x20, then reset while the access is in flight.
                @(negedge clk);
                mem_read_in    = 1'b0;
                mem_write_in   = 1'b1;
                mem_address_in = 32'h0000_0020;
                write_data_in  = 32'h0000_0055;
                @(posedge clk);
                #1;
                reset = 1'b1;
                #1;
                check_zero("async reset");
                @(posedge clk);
                @(negedge clk);
                reset = 1'b0;
                drive_idle();
            end
            // 0x20 keeps 0x11 (mid-access reset and misaligned store both discarded).
            run_op(lat, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 5'd1, 1'b1, 1'b1,
                   32'h0000_0011, 1'b1, 1'b0, 1'b1, "reload 0x20");

            // Random traffic against the model, from a fresh reset.
            reset_pulse();
            m_rdata = 32'd0;
            for (int w = 0; w < 16; w++) model_op(lat, 2, w);
            for (int i = 0; i < 60; i++) model_op(lat, $urandom_range(0, 4), $urandom_range(0, 15));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
